// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction memory / program loader.
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM: one synchronous read port, one write port.
import imem_pkg::*;

module imem_ram #(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_load_arb.sv
// Arbitrates the instruction RAM between CPU fetch and a program loader.
// Define IMEM_LOAD_SUM_EN to build the load checksum accumulator.
import imem_pkg::*;

module imem_load_arb #(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic [31:0]       fetch_instr,
    output logic              fetch_valid,
    output logic              cpu_stall,
    input  logic              load_start,
    input  logic [31:0]       load_base,
    input  logic              load_valid,
    input  logic [31:0]       load_wdata,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              load_ovf,
    output logic [31:0]       load_sum
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = DEPTH[ADDR_W:0];

    imem_state_t       state_q, state_d;
    logic              pend_q;
    logic              fv_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic              ovf_q;
    logic [31:0]       rdata;

    logic run_idle, start_acc, rd_en, wr_en;

    assign run_idle  = (state_q == RUN) && !pend_q;
    assign start_acc = run_idle && load_start;
    assign rd_en     = run_idle && fetch_req;
    assign wr_en     = (state_q == LOAD) && load_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (pend_q || (load_start && !fetch_req)) state_d = LOAD;
            LOAD:    if (load_valid && load_last) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // A start that collides with a fetch waits one cycle so the fetch lands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= start_acc && fetch_req;
            fv_q    <= rd_en;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (start_acc) begin
            addr_q <= load_base[ADDR_W+1:2];
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (wr_en) begin
            addr_q <= addr_q + 1'b1;
            if (cnt_q == CNT_FULL) ovf_q <= 1'b1;
            else                   cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef IMEM_LOAD_SUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          sum_q <= '0;
        else if (start_acc) sum_q <= '0;
        else if (wr_en)     sum_q <= sum_q + load_wdata;
    end

    assign load_sum = sum_q;
`else
    assign load_sum = '0;
`endif

    imem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .re    (rd_en),
        .raddr (fetch_pc[ADDR_W+1:2]),
        .rdata (rdata),
        .we    (wr_en),
        .waddr (addr_q),
        .wdata (load_wdata)
    );

    assign fetch_valid = fv_q;
    assign fetch_instr = fv_q ? rdata : '0;
    assign cpu_stall   = (state_q != RUN) || pend_q;
    assign load_ready  = (state_q == LOAD);
    assign load_done   = (state_q == DONE);
    assign load_count  = cnt_q;
    assign load_ovf    = ovf_q;

    logic unused;
    assign unused = ^{fetch_pc[31:ADDR_W+2], fetch_pc[1:0],
                      load_base[31:ADDR_W+2], load_base[1:0]};

endmodule

// File: tb/tb_imem_load_arb.sv
// Directed self-checking bench for imem_load_arb.
module tb_imem_load_arb;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rstn;
    logic              fetch_req;
    logic [31:0]       fetch_pc;
    logic [31:0]       fetch_instr;
    logic              fetch_valid;
    logic              cpu_stall;
    logic              load_start;
    logic [31:0]       load_base;
    logic              load_valid;
    logic [31:0]       load_wdata;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              load_ovf;
    logic [31:0]       load_sum;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wq[$];
    logic [31:0] exp_sum;

    always #5 clk = ~clk;

    imem_load_arb #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .fetch_valid (fetch_valid),
        .cpu_stall   (cpu_stall),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_valid  (load_valid),
        .load_wdata  (load_wdata),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_count  (load_count),
        .load_ovf    (load_ovf),
        .load_sum    (load_sum)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sum_exp(input logic [31:0] s);
`ifdef IMEM_LOAD_SUM_EN
        return s;
`else
        return 32'h0;
`endif
    endfunction

    task automatic fetch(input string tag, input logic [31:0] pc,
                         input logic [31:0] exp);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        step();
        fetch_req = 1'b0;
        chk({tag, "_v"}, {31'b0, fetch_valid}, 32'h1);
        chk(tag, fetch_instr, exp);
    endtask

    // Streams wq starting at base; ends one cycle after DONE, back in RUN.
    task automatic do_load(input string tag, input logic [31:0] base);
        load_start = 1'b1;
        load_base  = base;
        step();
        load_start = 1'b0;
        chk({tag, "_stall"}, {31'b0, cpu_stall}, 32'h1);
        chk({tag, "_rdy"}, {31'b0, load_ready}, 32'h1);
        exp_sum = '0;
        for (int i = 0; i < wq.size(); i++) begin
            load_valid = 1'b1;
            load_wdata = wq[i];
            load_last  = (i == wq.size() - 1);
            exp_sum    = exp_sum + wq[i];
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk({tag, "_done"}, {31'b0, load_done}, 32'h1);
        chk({tag, "_done_rdy"}, {31'b0, load_ready}, 32'h0);
        step();
        chk({tag, "_done_pulse"}, {31'b0, load_done}, 32'h0);
        chk({tag, "_run_stall"}, {31'b0, cpu_stall}, 32'h0);
    endtask

    initial begin
        rstn       = 1'b0;
        fetch_req  = 1'b0;
        fetch_pc   = '0;
        load_start = 1'b0;
        load_base  = '0;
        load_valid = 1'b0;
        load_wdata = '0;
        load_last  = 1'b0;
        #12;
        chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
        chk("rst_instr", fetch_instr, 32'h0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
        chk("rst_rdy", {31'b0, load_ready}, 32'h0);
        chk("rst_done", {31'b0, load_done}, 32'h0);
        chk("rst_cnt", 32'(load_count), 32'h0);
        chk("rst_ovf", {31'b0, load_ovf}, 32'h0);
        chk("rst_sum", load_sum, 32'h0);
        rstn = 1'b1;
        step();

        fetch("f0_init", 32'h0, 32'h0);
        step();
        chk("f_idle_v", {31'b0, fetch_valid}, 32'h0);

        wq = '{32'h00000037, 32'h000000B7, 32'h02002103};
        do_load("l3", 32'h0);
        chk("l3_cnt", 32'(load_count), 32'd3);
        chk("l3_ovf", {31'b0, load_ovf}, 32'h0);
        chk("l3_sum", load_sum, sum_exp(32'h020021F1));
        fetch("l3_f0", 32'h0, 32'h00000037);
        fetch("l3_f4", 32'h4, 32'h000000B7);
        fetch("l3_f8", 32'h8, 32'h02002103);

        wq = '{32'h11111111, 32'h22222222};
        do_load("wrap", 32'hFFC);
        chk("wrap_cnt", 32'(load_count), 32'd2);
        chk("wrap_ovf", {31'b0, load_ovf}, 32'h0);
        chk("wrap_sum", load_sum, sum_exp(32'h33333333));
        fetch("wrap_f1023", 32'hFFC, 32'h11111111);
        fetch("wrap_f0", 32'h0, 32'h22222222);
        fetch("wrap_f1", 32'h4, 32'h000000B7);

        load_valid = 1'b1;
        load_wdata = 32'hBADBAD00;
        load_last  = 1'b1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk("run_lv_cnt", 32'(load_count), 32'd2);
        chk("run_lv_stall", {31'b0, cpu_stall}, 32'h0);
        fetch("run_lv_f0", 32'h0, 32'h22222222);

        wq.delete();
        for (int i = 0; i < 1025; i++) wq.push_back(32'hA5000000 + i);
        do_load("big", 32'h0);
        chk("big_cnt", 32'(load_count), 32'd1024);
        chk("big_ovf", {31'b0, load_ovf}, 32'h1);
        chk("big_sum", load_sum, sum_exp(exp_sum));
        fetch("big_f0", 32'h0, 32'hA5000400);
        fetch("big_f1", 32'h4, 32'hA5000001);
        fetch("big_f1023", 32'hFFC, 32'hA50003FF);

        load_start = 1'b1;
        load_base  = 32'h100;
        fetch_req  = 1'b1;
        fetch_pc   = 32'h8;
        step();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        chk("both_fv", {31'b0, fetch_valid}, 32'h1);
        chk("both_instr", fetch_instr, 32'hA5000002);
        step();
        chk("both_stall", {31'b0, cpu_stall}, 32'h1);
        chk("both_rdy", {31'b0, load_ready}, 32'h1);
        chk("both_fv_off", {31'b0, fetch_valid}, 32'h0);
        chk("both_cnt", 32'(load_count), 32'h0);
        chk("both_ovf", {31'b0, load_ovf}, 32'h0);

        fetch_req = 1'b1;
        fetch_pc  = 32'h0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_wdata = 32'hDEAD0001 + i;
            step();
        end
        load_valid = 1'b0;
        fetch_req  = 1'b0;
        chk("mid_fv_ign", {31'b0, fetch_valid}, 32'h0);
        chk("mid_cnt", 32'(load_count), 32'd2);
        chk("mid_sum", load_sum, sum_exp(32'hBD5A0003));

        rstn = 1'b0;
        #1;
        chk("mrst_stall", {31'b0, cpu_stall}, 32'h0);
        chk("mrst_rdy", {31'b0, load_ready}, 32'h0);
        chk("mrst_cnt", 32'(load_count), 32'h0);
        chk("mrst_sum", load_sum, 32'h0);
        step();
        rstn = 1'b1;
        step();
        chk("mrst_run", {31'b0, cpu_stall}, 32'h0);
        fetch("mrst_f64", 32'h100, 32'hDEAD0001);
        fetch("mrst_f65", 32'h104, 32'hDEAD0002);
        fetch("mrst_f66", 32'h108, 32'hA5000042);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
